animation_sequencer: RTL

- Sequences the 7-segment animation datapath: selects the active animation index and steps its frame counter at a programmable rate.
- Wraps the frame counter at the per-animation frame count returned by the limit lookup table.
- `animation` drives the limit table combinationally. `limit` is fed back, and `animation`/`frame` go to the segment pattern ROM.
- Supports manual selection, auto-cycling through all animations, pause and single-step.

---
 rtl/animation_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/animation_sequencer.sv
// animation_sequencer: picks the active 7-segment animation and steps its frame
// counter at a programmable rate. Supports manual select, auto-cycling, pause,
// and single-step.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   RUN     | prescaler counts; a tick advances the frame
//   PAUSED  | prescaler holds; a rising edge on step advances the frame
//   SWITCH  | one cycle after loading a new animation; frame and prescaler stay 0
module animation_sequencer #(
  parameter int unsigned TICK_DIV = 1000000,
  parameter int unsigned NUM_ANI  = 51,
  parameter int unsigned LOOPS    = 3,
  parameter int unsigned PW       = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [5:0] sel_ani,
  input  logic       auto_mode,
  input  logic       pause,
  input  logic       step,
  input  logic [1:0] speed,
  input  logic [5:0] limit,
  output logic [5:0] animation,
  output logic [5:0] frame,
  output logic       frame_tick,
  output logic       wrap
);

  localparam int unsigned LW = (LOOPS < 1) ? 1 : $clog2(LOOPS + 1);
  localparam logic [LW-1:0] LOOPS_V = LW'(LOOPS);
  localparam logic [5:0] MAX_ANI = 6'(NUM_ANI - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    animation_q, animation_d;
  logic [5:0]    frame_q, frame_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [LW-1:0] loop_q, loop_d;
  logic          step_q, step_d;
  logic          auto_q, auto_d;
  logic          frame_tick_q, frame_tick_d;
  logic          wrap_q, wrap_d;

  logic [5:0]    sel_clamp;
  logic [5:0]    ani_next_auto;
  logic [5:0]    eff_lim;
  logic [6:0]    frame_inc;
  logic [PW-1:0] period_m1;
  logic          step_rise;
  logic          mode_chg;
  logic          auto_req;
  logic          man_req;
  logic          adv;

  // Decode helpers: clamped select, auto successor, effective limit and period.
  always_comb begin
    sel_clamp     = (sel_ani > MAX_ANI) ? MAX_ANI : sel_ani;
    ani_next_auto = (animation_q >= MAX_ANI) ? 6'd0 : animation_q + 6'd1;
    eff_lim       = (limit == 6'd0) ? 6'd1 : limit;
    frame_inc     = {1'b0, frame_q} + 7'd1;
    period_m1     = (PW'(TICK_DIV) << speed) - PW'(1);
    step_rise     = step & ~step_q;
    mode_chg      = auto_mode != auto_q;
    // A mode transition clears the loop counter, so suppress an auto switch on that cycle.
    auto_req      = auto_mode && !mode_chg && (loop_q == LOOPS_V);
    man_req       = !auto_mode && (sel_clamp != animation_q);
  end

  // Next-state and datapath: switch > pause > tick/step > limit-shrink correction.
  always_comb begin
    state_d      = state_q;
    animation_d  = animation_q;
    frame_d      = frame_q;
    presc_d      = presc_q;
    loop_d       = loop_q;
    step_d       = step_q;
    auto_d       = auto_q;
    frame_tick_d = 1'b0;
    wrap_d       = 1'b0;
    adv          = 1'b0;

    if (ena) begin
      step_d = step;
      auto_d = auto_mode;

      case (state_q)
        ST_SWITCH: begin
          state_d = pause ? ST_PAUSED : ST_RUN;
        end
        default: begin
          if (auto_req || man_req) begin
            state_d      = ST_SWITCH;
            animation_d  = auto_req ? ani_next_auto : sel_clamp;
            frame_d      = 6'd0;
            presc_d      = '0;
            loop_d       = '0;
            frame_tick_d = 1'b1;
          end else if (state_q == ST_RUN && pause) begin
            // Entering pause discards any tick due this cycle; prescaler holds.
            state_d = ST_PAUSED;
          end else if (state_q == ST_PAUSED && !pause) begin
            state_d = ST_RUN;
          end else begin
            if (state_q == ST_RUN) begin
              if (presc_q >= period_m1) begin
                presc_d = '0;
                adv     = 1'b1;
              end else begin
                presc_d = presc_q + PW'(1);
              end
            end else begin
              adv = step_rise;
            end

            if (adv) begin
              frame_tick_d = 1'b1;
              if (frame_inc >= {1'b0, eff_lim}) begin
                frame_d = 6'd0;
                wrap_d  = 1'b1;
                loop_d  = (loop_q == LOOPS_V) ? loop_q : loop_q + LW'(1);
              end else begin
                frame_d = frame_inc[5:0];
              end
            end else if (frame_q >= eff_lim) begin
              frame_d      = 6'd0;
              frame_tick_d = 1'b1;
            end
          end
        end
      endcase

      if (mode_chg) begin
        loop_d = '0;
      end
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      animation_q  <= 6'd0;
      frame_q      <= 6'd0;
      presc_q      <= '0;
      loop_q       <= '0;
      step_q       <= 1'b0;
      auto_q       <= 1'b0;
      frame_tick_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      animation_q  <= animation_d;
      frame_q      <= frame_d;
      presc_q      <= presc_d;
      loop_q       <= loop_d;
      step_q       <= step_d;
      auto_q       <= auto_d;
      frame_tick_q <= frame_tick_d;
      wrap_q       <= wrap_d;
    end
  end

  assign animation  = animation_q;
  assign frame      = frame_q;
  assign frame_tick = frame_tick_q;
  assign wrap       = wrap_q;

endmodule
